// File: rtl/instr_fetch.sv
// Instruction sequencer: owns the PC, fetches from a 1-cycle synchronous instruction
// memory and issues opcode/literal pairs to the decoder with a one-cycle qualifier.
module instr_fetch #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned INSTR_W     = 15,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic               stall,
  output logic               mem_rd_en,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [6:0]         opcode,
  output logic [7:0]         k8,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam int unsigned OP_W = 7;
  localparam int unsigned K_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   issue_c;

  // Next-state and issue qualifier; stall can only be honoured combinationally in ISSUE
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (opcode == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if (!stall) begin
          issue_c = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_rd_en <= 1'b0;
      opcode    <= '0;
      k8        <= '0;
      pc        <= '0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_rd_en <= (state_d == S_FETCH);
      if (state_q == S_WAIT) begin
        opcode <= mem_rdata[K_W +: OP_W];
        k8     <= mem_rdata[K_W-1:0];
      end
      if (issue_c) pc <= pc + PC_W'(1);
      if (state_d == S_HALT) halted <= 1'b1;
    end
  end

  assign instr_valid = issue_c;
  assign mem_addr    = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetches/issues are queued from a memory
// model as stimulus is set up and retired by a monitor on the falling edge.
module tb_instr_fetch;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 15;

  typedef struct packed {
    logic [6:0]      op;
    logic [7:0]      k;
    logic [PC_W-1:0] pc;
  } issue_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run, step, stall;
  logic               mem_rd_en;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [6:0]         opcode;
  logic [7:0]         k8;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;

  logic [INSTR_W-1:0] mem [256];

  int tests_run    = 0;
  int tests_failed = 0;
  int unsigned cyc = 0;
  int fetch_seen   = 0;
  int iv_seen      = 0;
  int iv_cyc_q [$];
  logic [PC_W-1:0] fetch_q [$];
  issue_t          issue_q [$];
  logic prev_iv = 1'b0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .stall       (stall),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .opcode      (opcode),
    .k8          (k8),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor retires fetches and issues against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_rd_en) begin
        fetch_seen++;
        if (fetch_q.size() == 0) check("fetch_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        else check("fetch_addr", 32'(mem_addr), 32'(fetch_q.pop_front()));
      end
      if (instr_valid) begin
        issue_t e;
        iv_seen++;
        iv_cyc_q.push_back(int'(cyc));
        check("iv_back_to_back", 32'(prev_iv), 32'd0);
        if (issue_q.size() == 0) begin
          check("issue_unexpected", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = issue_q.pop_front();
          check("issue_opcode", 32'(opcode), 32'(e.op));
          check("issue_k8",     32'(k8),     32'(e.k));
          check("issue_pc",     32'(pc),     32'(e.pc));
        end
      end
      prev_iv <= instr_valid;
    end else begin
      prev_iv <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input int addr);
    fetch_q.push_back(PC_W'(addr));
  endtask

  task automatic push_issue(input int addr);
    issue_t e;
    e.op = mem[addr][14:8];
    e.k  = mem[addr][7:0];
    e.pc = PC_W'(addr);
    issue_q.push_back(e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_fetch(input int target);
    int n;
    n = 0;
    while (fetch_seen < target && n < 2000) begin
      tick();
      n++;
    end
    if (fetch_seen < target) check("fetch_timeout", 32'(fetch_seen), 32'(target));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_fetch_q_empty"}, 32'(fetch_q.size()), 32'd0);
    check({tag, "_issue_q_empty"}, 32'(issue_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, iv0, run_cyc;
    for (int i = 0; i < 256; i++) mem[i] = 15'h0100;

    // Reset state, asynchronous
    rst_n = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0;
    #2;
    check("rst_pc",          32'(pc),          32'd0);
    check("rst_opcode",      32'(opcode),      32'd0);
    check("rst_k8",          32'(k8),          32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_mem_rd_en",   32'(mem_rd_en),   32'd0);
    check("rst_mem_addr",    32'(mem_addr),    32'd0);
    check("rst_halted",      32'(halted),      32'd0);

    // Free run over two instructions into a halt
    mem[0] = 15'h0205; mem[1] = 15'h0603; mem[2] = 15'h7F00;
    do_reset();
    push_fetch(0); push_issue(0);
    push_fetch(1); push_issue(1);
    push_fetch(2);
    iv_cyc_q.delete();
    tick();
    run_cyc = int'(cyc);
    run = 1'b1;
    wait_fetch(fetch_seen + 3);
    repeat (4) tick();
    check("t1_iv_count", 32'(iv_cyc_q.size()), 32'd2);
    if (iv_cyc_q.size() >= 2) begin
      check("t1_first_latency", 32'(iv_cyc_q[0]), 32'(run_cyc + 3));
      check("t1_iv_spacing", 32'(iv_cyc_q[1] - iv_cyc_q[0]), 32'd3);
    end
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_pc", 32'(pc), 32'd2);
    check_drained("t1");

    // Halt is absorbing: run held and step pulsed
    fs = fetch_seen; iv0 = iv_seen;
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      tick();
    end
    step = 1'b0;
    check("t2_no_fetch", 32'(fetch_seen), 32'(fs));
    check("t2_no_issue", 32'(iv_seen), 32'(iv0));
    check("t2_halted_hold", 32'(halted), 32'd1);
    check("t2_pc_hold", 32'(pc), 32'd2);

    // Single step, second step pulse in WAIT ignored
    do_reset();
    mem[0] = 15'h1011; mem[1] = 15'h2233;
    push_fetch(0); push_issue(0);
    iv0 = iv_seen;
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0;
    repeat (8) tick();
    check("t3_one_issue", 32'(iv_seen - iv0), 32'd1);
    check("t3_pc", 32'(pc), 32'd1);
    check("t3_halted", 32'(halted), 32'd0);
    check_drained("t3");

    // Stall held four cycles on ISSUE entry
    push_fetch(1); push_issue(1);
    iv0 = iv_seen;
    step = 1'b1; tick();
    step = 1'b0; tick();
    stall = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall_iv",     32'(instr_valid), 32'd0);
      check("t4_stall_opcode", 32'(opcode),      32'h22);
      check("t4_stall_k8",     32'(k8),          32'h33);
      check("t4_stall_pc",     32'(pc),          32'd1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("t4_release_iv", 32'(instr_valid), 32'd1);
    repeat (6) tick();
    check("t4_one_issue", 32'(iv_seen - iv0), 32'd1);
    check("t4_pc", 32'(pc), 32'd2);
    check_drained("t4");

    // PC wrap 255 -> 0
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = {7'((i % 64) + 1), 8'(255 - i)};
    for (int i = 0; i < 256; i++) begin
      push_fetch(i); push_issue(i);
    end
    push_fetch(0); push_issue(0);
    fs = fetch_seen;
    run = 1'b1;
    wait_fetch(fs + 257);
    run = 1'b0;
    repeat (6) tick();
    check("t5_pc_after_wrap", 32'(pc), 32'd1);
    check("t5_halted", 32'(halted), 32'd0);
    check("t5_fetch_count", 32'(fetch_seen - fs), 32'd257);
    check_drained("t5");

    // Asynchronous reset while in WAIT
    do_reset();
    mem[0] = 15'h0A0B; mem[1] = 15'h0C0D;
    push_fetch(0); push_issue(0); push_fetch(1);
    fs = fetch_seen;
    run = 1'b1;
    wait_fetch(fs + 2);
    check("t6_pre_opcode", 32'(opcode), 32'h0A);
    check("t6_pre_pc", 32'(pc), 32'd1);
    #2 rst_n = 1'b0; run = 1'b0;
    #1;
    check("t6_rst_mem_rd_en", 32'(mem_rd_en),   32'd0);
    check("t6_rst_iv",        32'(instr_valid), 32'd0);
    check("t6_rst_pc",        32'(pc),          32'd0);
    check("t6_rst_opcode",    32'(opcode),      32'd0);
    check("t6_rst_k8",        32'(k8),          32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t6_no_fetch", 32'(fetch_seen), 32'(fs + 2));
    check("t6_idle_pc", 32'(pc), 32'd0);
    check("t6_idle_rd_en", 32'(mem_rd_en), 32'd0);
    check_drained("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction sequencer that feeds the opcode decoder.
- Owns the program counter and reads instruction memory, which has a 1-cycle synchronous read.
- Splits each instruction word into a 7-bit opcode and an 8-bit literal, then issues them with a one-cycle qualifier. Datapath register loads are enabled only when LA/LB coincide with instr_valid.
- Supports free-run, single-step, stall and a halt opcode.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 15, instruction word width; bits [14:8] are the opcode, bits [7:0] are the literal k8
HALT_OPCODE, 7'b1111111, opcode that stops fetching; it is never issued to the decoder

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = fetch continuously
step  input  1  single-cycle pulse; fetch and issue exactly one instruction while run=0
stall  input  1  level; holds the instruction currently in ISSUE
mem_rd_en  output  1  instruction memory read strobe
mem_addr  output  PC_W  instruction memory address
mem_rdata  input  INSTR_W  read data, valid the cycle after mem_rd_en
opcode  output  7  current opcode to the decoder
k8  output  8  current literal
instr_valid  output  1  one-cycle strobe; the instruction is executed this cycle
pc  output  PC_W  current program counter
halted  output  1  sticky; HALT_OPCODE reached

Behaviour:
- Reset, asynchronous on rst_n low, takes effect with no clock edge needed:
  - state=IDLE; pc=0; opcode=0; k8=0; instr_valid=0; mem_rd_en=0; mem_addr=0; halted=0.
  - Reset mid-operation aborts the instruction in flight; nothing is issued.
- mem_addr always equals pc.
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE:
  - run=1 → FETCH.
  - run=0 and step=1 → FETCH in step mode.
  - Otherwise stay in IDLE.
- FETCH: mem_rd_en=1 for exactly this cycle → WAIT.
- WAIT: opcode/k8 capture mem_rdata[14:8] and mem_rdata[7:0] at the end of the cycle → ISSUE.
- ISSUE, in priority order:
  - opcode == HALT_OPCODE: instr_valid=0 → HALT; pc unchanged; halted=1 from the next cycle.
  - stall=1: instr_valid=0; remain in ISSUE; opcode/k8/pc stable.
  - Otherwise instr_valid=1 for this cycle, and pc <= pc+1 modulo 2^PC_W (255→0 with no flag). Next state is FETCH if run=1, else IDLE.
- HALT: absorbing until reset. mem_rd_en=0, instr_valid=0, halted=1; run/step ignored.
- Throughput: 3 cycles per instruction with no stall. After the edge that samples run=1 in IDLE, instr_valid rises 2 cycles later.
- run and step interaction:
  - step is ignored when run=1 and in any state other than IDLE; steps are not queued.
  - Deasserting run mid-instruction lets the current instruction complete its issue, then the block goes to IDLE.
- stall is ignored in IDLE/FETCH/WAIT; it is honoured only in ISSUE.
- Outside ISSUE, opcode/k8 hold their last captured values; instr_valid is the only qualifier.
- instr_valid never asserts in two consecutive cycles.

Test Plan:
1. mem[0]=0x0205 (MOV A,5), mem[1]=0x0603 (ADD A,3); reset release, run=1 → mem_rd_en pulses at addr 0 then 1; instr_valid pulses 3 cycles apart with opcode=0x02/k8=0x05, then opcode=0x06/k8=0x03; pc 0→1→2.
2. mem[2]=0x7F00 after test 1 → no instr_valid for addr 2; halted=1; pc stays 2; mem_rd_en stays 0 for 20 further cycles even with run=1 and step pulses.
3. run=0, single step pulse → exactly one instr_valid, return to IDLE, pc+1. A second step pulse issued during WAIT → ignored: still only one instr_valid and pc+1 total.
4. stall=1 on ISSUE entry, held 4 cycles → instr_valid=0, opcode/k8/pc stable for 4 cycles; on stall release → exactly one instr_valid pulse, then pc+1.
5. Preload pc=255 by running from 0 over 255 non-halt words, run=1 → after issue at addr 255, pc=0 and next mem_addr=0; halted=0.
6. rst_n driven low mid-cycle while in WAIT → mem_rd_en, instr_valid, pc, opcode and k8 go to 0 before the next clk edge; after release with run=0 → stays IDLE and no fetch occurs.
